// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between execute and write-back.
// One operation in flight. Non-memory ops pass straight through to write-back.
// Aligned loads/stores issue one request on the data-memory port and wait for ack.
// Misaligned accesses are rejected without touching memory.
// Optional feature macro: MEM_LSU_TIMEOUT_EN. When it is defined, a wait-cycle counter
// aborts a request that gets no ack within TIMEOUT_CYC cycles and reports bus_err_o.
//
// Handshake: an op is accepted on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE and never while rst is high. out_valid is a one-cycle
// pulse per accepted op. It is qualified by misalign_o and bus_err_o.
// dmem_req_o stays high until the edge that samples dmem_ack_i=1.

`ifndef ALUOP_ADD
`define ALUOP_ADD 5'd0
`define ALUOP_SUB 5'd1
`define ALUOP_AND 5'd2
`define ALUOP_OR  5'd3
`define ALUOP_XOR 5'd4
`define ALUOP_LB  5'd16
`define ALUOP_LH  5'd17
`define ALUOP_LW  5'd18
`define ALUOP_LBU 5'd19
`define ALUOP_LHU 5'd20
`define ALUOP_SB  5'd21
`define ALUOP_SH  5'd22
`define ALUOP_SW  5'd23
`endif

module mem_lsu #(
   parameter int ADDR_W      = 12,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        aluop_i,
   input  logic              wreg_i,
   input  logic [4:0]        rd_addr_i,
   input  logic [31:0]       rd_data_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       rs2_i,
   output logic              out_valid,
   output logic              wreg_o,
   output logic [4:0]        rd_addr_o,
   output logic [31:0]       rd_data_o,
   output logic              misalign_o,
   output logic              bus_err_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [3:0]        dmem_sel_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [31:0]       dmem_wdata_o,
   input  logic              dmem_ack_i,
   input  logic [31:0]       dmem_rdata_i,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Access size codes: 0 = byte, 1 = half, 2 = word.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   state_t      state;

   // Decode of the incoming op.
   logic        dec_load;
   logic        dec_store;
   logic [1:0]  dec_size;
   logic        dec_signed;
   logic        dec_mem;
   logic        dec_misalign;
   logic [1:0]  off;
   logic [3:0]  sel_c;
   logic [31:0] wdata_c;

   // Op context held while the request is outstanding.
   logic        op_load_q;
   logic [1:0]  op_size_q;
   logic        op_signed_q;
   logic [1:0]  op_off_q;
   logic        op_wreg_q;
   logic [4:0]  op_rd_q;

   // Load data after lane selection and extension.
   logic [31:0] rdata_shift;
   logic [31:0] load_val;

   assign off          = mem_addr_i[1:0];
   assign dec_mem      = dec_load | dec_store;
   assign dec_misalign = dec_mem &&
                         (((dec_size == SZ_H) && off[0]) ||
                          ((dec_size == SZ_W) && (off != 2'd0)));
   assign in_ready     = (state == S_IDLE) && !rst;
   assign dbg_state    = state;

   // Classify the op code into load/store, access size and signedness.
   always_comb begin
      dec_load   = 1'b0;
      dec_store  = 1'b0;
      dec_size   = SZ_W;
      dec_signed = 1'b0;
      case (aluop_i)
         `ALUOP_LB:  begin dec_load  = 1'b1; dec_size = SZ_B; dec_signed = 1'b1; end
         `ALUOP_LH:  begin dec_load  = 1'b1; dec_size = SZ_H; dec_signed = 1'b1; end
         `ALUOP_LW:  begin dec_load  = 1'b1; dec_size = SZ_W; end
         `ALUOP_LBU: begin dec_load  = 1'b1; dec_size = SZ_B; end
         `ALUOP_LHU: begin dec_load  = 1'b1; dec_size = SZ_H; end
         `ALUOP_SB:  begin dec_store = 1'b1; dec_size = SZ_B; end
         `ALUOP_SH:  begin dec_store = 1'b1; dec_size = SZ_H; end
         `ALUOP_SW:  begin dec_store = 1'b1; dec_size = SZ_W; end
         default:    ;
      endcase
   end

   // Byte-lane enables and lane-replicated store data for the incoming op.
   always_comb begin
      sel_c   = 4'b0000;
      wdata_c = 32'd0;
      case (dec_size)
         SZ_B: begin
            sel_c   = 4'b0001 << off;
            wdata_c = {4{rs2_i[7:0]}};
         end
         SZ_H: begin
            sel_c   = 4'b0011 << off;
            wdata_c = {2{rs2_i[15:0]}};
         end
         default: begin
            sel_c   = 4'b1111;
            wdata_c = rs2_i;
         end
      endcase
   end

   // Pick the addressed byte/half out of the read word and extend it.
   always_comb begin
      rdata_shift = dmem_rdata_i >> {op_off_q, 3'b000};
      load_val    = dmem_rdata_i;
      case (op_size_q)
         SZ_B:    load_val = {{24{op_signed_q & rdata_shift[7]}},  rdata_shift[7:0]};
         SZ_H:    load_val = {{16{op_signed_q & rdata_shift[15]}}, rdata_shift[15:0]};
         default: load_val = dmem_rdata_i;
      endcase
   end

`ifdef MEM_LSU_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] to_cnt;
`else
   // Without the timeout feature a request waits for ack indefinitely.
   assign bus_err_o = 1'b0;
`endif

   // Control FSM with all outputs registered. Result fields are cleared outside the out_valid cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         out_valid    <= 1'b0;
         wreg_o       <= 1'b0;
         rd_addr_o    <= 5'd0;
         rd_data_o    <= 32'd0;
         misalign_o   <= 1'b0;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_sel_o   <= 4'd0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= 32'd0;
         op_load_q    <= 1'b0;
         op_size_q    <= SZ_W;
         op_signed_q  <= 1'b0;
         op_off_q     <= 2'd0;
         op_wreg_q    <= 1'b0;
         op_rd_q      <= 5'd0;
`ifdef MEM_LSU_TIMEOUT_EN
         bus_err_o    <= 1'b0;
         to_cnt       <= '0;
`endif
      end else begin
         out_valid  <= 1'b0;
         wreg_o     <= 1'b0;
         rd_addr_o  <= 5'd0;
         rd_data_o  <= 32'd0;
         misalign_o <= 1'b0;
`ifdef MEM_LSU_TIMEOUT_EN
         bus_err_o  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (!dec_mem) begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     wreg_o    <= wreg_i;
                     rd_addr_o <= rd_addr_i;
                     rd_data_o <= rd_data_i;
                  end else if (dec_misalign) begin
                     state      <= S_DONE;
                     out_valid  <= 1'b1;
                     misalign_o <= 1'b1;
                  end else begin
                     state        <= S_WAIT;
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= dec_store;
                     dmem_sel_o   <= sel_c;
                     dmem_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                     dmem_wdata_o <= dec_store ? wdata_c : 32'd0;
                     op_load_q    <= dec_load;
                     op_size_q    <= dec_size;
                     op_signed_q  <= dec_signed;
                     op_off_q     <= off;
                     op_wreg_q    <= wreg_i;
                     op_rd_q      <= rd_addr_i;
`ifdef MEM_LSU_TIMEOUT_EN
                     to_cnt       <= '0;
`endif
                  end
               end
            end
            S_WAIT: begin
               if (dmem_ack_i) begin
                  state        <= S_DONE;
                  out_valid    <= 1'b1;
                  dmem_req_o   <= 1'b0;
                  dmem_we_o    <= 1'b0;
                  dmem_sel_o   <= 4'd0;
                  dmem_addr_o  <= '0;
                  dmem_wdata_o <= 32'd0;
                  if (op_load_q) begin
                     wreg_o    <= op_wreg_q;
                     rd_addr_o <= op_rd_q;
                     rd_data_o <= load_val;
                  end
               end
`ifdef MEM_LSU_TIMEOUT_EN
               else if (to_cnt == CNT_LAST) begin
                  state        <= S_DONE;
                  out_valid    <= 1'b1;
                  bus_err_o    <= 1'b1;
                  dmem_req_o   <= 1'b0;
                  dmem_we_o    <= 1'b0;
                  dmem_sel_o   <= 4'd0;
                  dmem_addr_o  <= '0;
                  dmem_wdata_o <= 32'd0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized bench for mem_lsu with a byte-addressed memory model.
// Expected results are computed from byte contents of the model memory.
// Build with MEM_LSU_TIMEOUT_EN defined to also cover the timeout path (TIMEOUT_CYC=4).

`ifndef ALUOP_ADD
`define ALUOP_ADD 5'd0
`define ALUOP_SUB 5'd1
`define ALUOP_AND 5'd2
`define ALUOP_OR  5'd3
`define ALUOP_XOR 5'd4
`define ALUOP_LB  5'd16
`define ALUOP_LH  5'd17
`define ALUOP_LW  5'd18
`define ALUOP_LBU 5'd19
`define ALUOP_LHU 5'd20
`define ALUOP_SB  5'd21
`define ALUOP_SH  5'd22
`define ALUOP_SW  5'd23
`endif

module tb_mem_lsu;
   localparam int ADDR_W = 12;
   localparam int TO_CYC = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [4:0]        aluop_i = 5'd0;
   logic              wreg_i = 1'b0;
   logic [4:0]        rd_addr_i = 5'd0;
   logic [31:0]       rd_data_i = 32'd0;
   logic [ADDR_W-1:0] mem_addr_i = '0;
   logic [31:0]       rs2_i = 32'd0;
   logic              out_valid;
   logic              wreg_o;
   logic [4:0]        rd_addr_o;
   logic [31:0]       rd_data_o;
   logic              misalign_o;
   logic              bus_err_o;
   logic              dmem_req_o;
   logic              dmem_we_o;
   logic [3:0]        dmem_sel_o;
   logic [ADDR_W-1:0] dmem_addr_o;
   logic [31:0]       dmem_wdata_o;
   logic              dmem_ack_i = 1'b0;
   logic [31:0]       dmem_rdata_i = 32'd0;
   logic [1:0]        dbg_state;

   int checks = 0;
   int failures = 0;

   logic [7:0]  mem_b [0:4095];
   logic [31:0] exp_q [$];

   mem_lsu #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .aluop_i(aluop_i), .wreg_i(wreg_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
      .mem_addr_i(mem_addr_i), .rs2_i(rs2_i),
      .out_valid(out_valid), .wreg_o(wreg_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_sel_o(dmem_sel_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .dbg_state(dbg_state)
   );

   // Clock and global time limit.
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model helpers.
   function automatic int op_size(input logic [4:0] op);
      case (op)
         `ALUOP_LB, `ALUOP_LBU, `ALUOP_SB: return 1;
         `ALUOP_LH, `ALUOP_LHU, `ALUOP_SH: return 2;
         `ALUOP_LW, `ALUOP_SW:             return 4;
         default:                          return 0;
      endcase
   endfunction

   function automatic bit op_is_load(input logic [4:0] op);
      return (op == `ALUOP_LB) || (op == `ALUOP_LH) || (op == `ALUOP_LW) ||
             (op == `ALUOP_LBU) || (op == `ALUOP_LHU);
   endfunction

   function automatic bit op_is_signed(input logic [4:0] op);
      return (op == `ALUOP_LB) || (op == `ALUOP_LH);
   endfunction

   function automatic logic [31:0] model_load(input int a, input int sz, input bit sgn);
      logic [31:0] v;
      v = 32'd0;
      for (int k = 0; k < sz; k++) v = v | (32'(mem_b[a + k]) << (8 * k));
      if (sgn && sz < 4 && v[8 * sz - 1]) v = v - (32'd1 << (8 * sz));
      return v;
   endfunction

   function automatic logic [31:0] mem_word(input int a);
      int b;
      b = (a / 4) * 4;
      return {mem_b[b + 3], mem_b[b + 2], mem_b[b + 1], mem_b[b]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Driver: issue one op and follow it to write-back. Entered and left at posedge+1.
   task automatic run_op(input logic [4:0] op, input int a, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic wr, input logic [31:0] rdat,
                         input int delay);
      int          sz;
      bit          is_mem;
      bit          mis;
      bit          ld;
      logic [31:0] exp_val;
      logic [3:0]  exp_sel;
      logic [31:0] exp_wd;
      logic [31:0] got_val;
      sz     = op_size(op);
      is_mem = (sz != 0);
      ld     = op_is_load(op);
      mis    = is_mem && ((a % sz) != 0);
      if (!is_mem)         exp_val = rdat;
      else if (mis || !ld) exp_val = 32'd0;
      else                 exp_val = model_load(a, sz, op_is_signed(op));
      exp_q.push_back(exp_val);
      exp_sel = 4'd0;
      exp_wd  = 32'd0;
      if (is_mem) begin
         for (int i = 0; i < 4; i++) begin
            if ((a % 4) <= i && i < (a % 4) + sz) exp_sel[i] = 1'b1;
            exp_wd[8 * i +: 8] = rs2[8 * (i % sz) +: 8];
         end
      end

      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      aluop_i    = op;
      mem_addr_i = ADDR_W'(a);
      rs2_i      = rs2;
      rd_addr_i  = rd;
      wreg_i     = wr;
      rd_data_i  = rdat;
      tick();
      // Keep presenting an aligned store; it must be ignored outside IDLE.
      aluop_i    = `ALUOP_SW;
      mem_addr_i = ADDR_W'($urandom_range(0, 1023) * 4);
      rd_data_i  = $urandom;

      if (is_mem && !mis) begin
         for (int c = 0; c <= delay; c++) begin
            check("req_wait", 32'(dmem_req_o), 32'd1);
            check("out_valid_wait", 32'(out_valid), 32'd0);
            check("in_ready_wait", 32'(in_ready), 32'd0);
            check("dmem_addr", 32'(dmem_addr_o), 32'((a / 4) * 4));
            check("dmem_sel", 32'(dmem_sel_o), 32'(exp_sel));
            check("dmem_we", 32'(dmem_we_o), 32'(!ld));
            if (!ld) check("dmem_wdata", dmem_wdata_o, exp_wd);
            if (c == delay) begin
               dmem_ack_i   = 1'b1;
               dmem_rdata_i = mem_word(a);
               if (!ld) for (int k = 0; k < sz; k++) mem_b[a + k] = rs2[8 * k +: 8];
            end
            tick();
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = $urandom;
         end
      end else begin
         check("no_req", 32'(dmem_req_o), 32'd0);
      end

      got_val = exp_q.pop_front();
      check("out_valid", 32'(out_valid), 32'd1);
      check("misalign", 32'(misalign_o), 32'(mis));
      check("bus_err", 32'(bus_err_o), 32'd0);
      check("wreg", 32'(wreg_o), 32'((!is_mem || (ld && !mis)) ? wr : 1'b0));
      if (!mis) begin
         check("rd_addr", 32'(rd_addr_o), 32'((!is_mem || ld) ? rd : 5'd0));
         check("rd_data", rd_data_o, got_val);
      end
      check("in_ready_done", 32'(in_ready), 32'd0);
      check("dmem_idle", {dmem_we_o, dmem_sel_o, dmem_addr_o, 15'd0} | 32'(dmem_req_o), 32'd0);
      check("dmem_wdata_idle", dmem_wdata_o, 32'd0);
      tick();
      in_valid = 1'b0;
      check("out_valid_pulse", 32'(out_valid), 32'd0);
      check("no_stray_req", 32'(dmem_req_o), 32'd0);
      check("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   // Reset in the third wait cycle of a load, followed by a late ack.
   task automatic reset_abort();
      check("abort_ready", 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      aluop_i    = `ALUOP_LW;
      mem_addr_i = ADDR_W'(16);
      rd_addr_i  = 5'd9;
      wreg_i     = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         check("abort_req", 32'(dmem_req_o), 32'd1);
         tick();
      end
      check("abort_req3", 32'(dmem_req_o), 32'd1);
      rst = 1'b1;
      tick();
      check("abort_req_drop", 32'(dmem_req_o), 32'd0);
      check("abort_no_valid", 32'(out_valid), 32'd0);
      check("abort_ready_rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("abort_ready_after", 32'(in_ready), 32'd1);
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'hDEAD_BEEF;
      tick();
      dmem_ack_i = 1'b0;
      check("late_ack_valid", 32'(out_valid), 32'd0);
      check("late_ack_req", 32'(dmem_req_o), 32'd0);
      tick();
      check("late_ack_valid2", 32'(out_valid), 32'd0);
   endtask

   // Main sequence.
   initial begin
      logic [4:0] ops [0:10];
      logic [4:0] op;
      int         a;
      int         sz;
      ops = '{`ALUOP_ADD, `ALUOP_XOR, `ALUOP_LB, `ALUOP_LH, `ALUOP_LW, `ALUOP_LBU,
              `ALUOP_LHU, `ALUOP_SB, `ALUOP_SH, `ALUOP_SW, `ALUOP_SUB};
      for (int i = 0; i < 4096; i++) mem_b[i] = 8'($urandom);

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_req", 32'(dmem_req_o), 32'd0);
      check("rst_rd_data", rd_data_o, 32'd0);
      check("rst_flags", {29'd0, wreg_o, misalign_o, bus_err_o}, 32'd0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", 32'(in_ready), 32'd1);

      run_op(`ALUOP_ADD, 0, 32'd0, 5'd5, 1'b1, 32'h0000_1234, 0);
      mem_b[0] = 8'h00; mem_b[1] = 8'h00; mem_b[2] = 8'hFF; mem_b[3] = 8'h80;
      run_op(`ALUOP_LB, 3, 32'd0, 5'd7, 1'b1, 32'd0, 0);
      run_op(`ALUOP_LBU, 3, 32'd0, 5'd8, 1'b1, 32'd0, 0);
      run_op(`ALUOP_SH, 6, 32'hAAAA_BEEF, 5'd3, 1'b1, 32'd0, 1);
      run_op(`ALUOP_LW, 4, 32'd0, 5'd4, 1'b1, 32'd0, 2);
      run_op(`ALUOP_LW, 2, 32'd0, 5'd6, 1'b1, 32'd0, 0);
      reset_abort();

`ifdef MEM_LSU_TIMEOUT_EN
      in_valid   = 1'b1;
      aluop_i    = `ALUOP_LW;
      mem_addr_i = ADDR_W'(32);
      wreg_i     = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < TO_CYC; c++) begin
         check("to_req", 32'(dmem_req_o), 32'd1);
         check("to_no_valid", 32'(out_valid), 32'd0);
         tick();
      end
      check("to_valid", 32'(out_valid), 32'd1);
      check("to_bus_err", 32'(bus_err_o), 32'd1);
      check("to_wreg", 32'(wreg_o), 32'd0);
      check("to_req_drop", 32'(dmem_req_o), 32'd0);
      tick();
      check("to_pulse", 32'(out_valid), 32'd0);
`endif

      for (int n = 0; n < 200; n++) begin
         op = ops[$urandom_range(0, 10)];
         sz = op_size(op);
         a  = $urandom_range(0, 4095);
         if (sz != 0 && $urandom_range(0, 2) != 0) a = (a / sz) * sz;
         run_op(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ADDR_W, default 12: byte-address width of the data-memory port.
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum wait cycles for dmem_ack_i (used only under MEM_LSU_TIMEOUT_EN).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  execute stage presents an operation.
REQ-006 in_ready  out  1  unit accepts an operation this cycle.
REQ-007 aluop_i  in  5  operation code, using the codebase `ALUOP_* encodings.
REQ-008 wreg_i, rd_addr_i, rd_data_i  in  1/5/32  write-back request, destination register, ALU result.
REQ-009 mem_addr_i  in  ADDR_W  byte address; rs2_i  in  32  store data.
REQ-010 out_valid  out  1  one-cycle pulse: result is valid for write-back.
REQ-011 wreg_o, rd_addr_o, rd_data_o  out  1/5/32  write-back request, destination register, result.
REQ-012 misalign_o  out  1  qualifies out_valid: access was misaligned and not performed.
REQ-013 bus_err_o  out  1  qualifies out_valid: access timed out.
REQ-014 dmem_req_o, dmem_we_o  out  1/1  memory request; write enable.
REQ-015 dmem_sel_o  out  4  byte-lane enables; dmem_addr_o  out  ADDR_W  word-aligned address, bits[1:0]=0.
REQ-016 dmem_wdata_o  out  32  lane-replicated store data.
REQ-017 dmem_ack_i  in  1  request complete; dmem_rdata_i  in  32  full read word, valid when dmem_ack_i=1.

Function
REQ-018 FSM states: IDLE, WAIT, DONE. in_ready SHALL be 1 only in IDLE; in_valid SHALL be ignored in any other state.
REQ-019 Non-memory op accepted in IDLE at edge N: out_valid SHALL be 1 in cycle N+1 with wreg_o/rd_addr_o/rd_data_o equal to the inputs; state SHALL go to DONE, then return to IDLE.
REQ-020 Aligned load/store accepted at edge N: state SHALL go to WAIT, with dmem_req_o=1 from cycle N+1 until the cycle in which dmem_ack_i=1, inclusive.
REQ-021 The unit SHALL sample dmem_ack_i only while dmem_req_o=1. The ack cycle M SHALL move the FSM to DONE, with out_valid=1 and dmem_req_o=0 in cycle M+1.
REQ-022 Byte lanes, with o=addr[1:0]: SB sel=0001<<o, wdata={4{rs2[7:0]}}. SH sel=0011<<o, wdata={2{rs2[15:0]}}. SW sel=1111, wdata=rs2.
REQ-023 Load byte = rdata[8*o+7:8*o]; load half = rdata[8*o+15:8*o]. LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word.
REQ-024 Loads SHALL drive wreg_o=wreg_i. Stores SHALL drive wreg_o=0, rd_addr_o=0, rd_data_o=0.
REQ-025 Misaligned access is a half with o[0]=1, or a word with o!=0. It SHALL issue no request and SHALL give out_valid at N+1 with misalign_o=1 and wreg_o=0.
REQ-026 When dmem_req_o=0, dmem_we_o, dmem_sel_o, dmem_addr_o and dmem_wdata_o SHALL all be 0.
REQ-027 out_valid SHALL be a single-cycle pulse per accepted op. DONE SHALL always go to IDLE, giving one bubble (in_ready=0) per op.

Reset
REQ-028 When rst=1 at an edge, the FSM SHALL go to IDLE, and every output except in_ready SHALL be 0 from the next cycle.
REQ-029 Reset during WAIT SHALL drop dmem_req_o at the next edge, with no out_valid for the aborted op. A late dmem_ack_i SHALL be ignored.
REQ-030 in_ready SHALL be 0 while rst=1.

Configuration
REQ-031 MEM_LSU_TIMEOUT_EN defined: a counter SHALL count WAIT cycles. After TIMEOUT_CYC cycles without ack, the unit SHALL drop dmem_req_o and enter DONE with out_valid=1, bus_err_o=1, wreg_o=0.
REQ-032 MEM_LSU_TIMEOUT_EN undefined: there SHALL be no counter, bus_err_o SHALL be constant 0, and WAIT SHALL last until ack.

Verification
REQ-033 ADD op, rd_data_i=0x1234, rd=5, in_valid at N -> out_valid at N+1, rd_data_o=0x1234, rd_addr_o=5, wreg_o=1.
REQ-034 LB addr=0x003, ack same cycle as first req, rdata=0x80FF_0000 -> dmem_addr_o=0x000, rd_data_o=0xFFFF_FF80. LBU of the same access -> 0x0000_0080.
REQ-035 SH addr=0x006, rs2=0xAAAA_BEEF -> dmem_sel_o=1100, dmem_wdata_o=0xBEEF_BEEF, dmem_we_o=1, out_valid with wreg_o=0.
REQ-036 LW addr=0x002 -> no dmem_req_o, out_valid at N+1, misalign_o=1, wreg_o=0.
REQ-037 LW with ack held off 5 cycles, rst pulsed in the 3rd wait cycle -> dmem_req_o=0 after the edge, no out_valid, in_ready=1 after rst drops.
REQ-038 Under MEM_LSU_TIMEOUT_EN with TIMEOUT_CYC=4, ack never given -> dmem_req_o high for 4 cycles, then out_valid=1, bus_err_o=1.
